// File: rtl/sid_pot_ctrl_pkg.sv
// Shared types and constants for the SID POTX/POTY measurement logic.
package sid_pot_ctrl_pkg;

  localparam int POT_PHASE_W = 9;
  localparam int POT_CH      = 2;

  typedef logic [7:0]             pot_val_t;
  typedef logic [POT_PHASE_W-1:0] pot_phase_t;

  typedef struct packed {
    logic [POT_CH-1:0] discharge;
  } pot_o_t;

  typedef struct packed {
    logic [POT_CH-1:0] charged;
  } pot_i_t;

  function automatic bit pot_param_ok(input int v);
    return (v >= 1) && (v <= 256);
  endfunction

endpackage

// File: rtl/sid_pot_channel.sv
// One POT pin: first-detect charge timer with sticky done and the published reading.
module sid_pot_channel
  import sid_pot_ctrl_pkg::*;
#(
  parameter int CHARGE_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res,
  input  logic       tick,
  input  logic       charge_active,
  input  logic       period_start,
  input  logic       period_end,
  input  logic [7:0] k,
  input  logic       charged,
  output logic [7:0] value
);

  localparam pot_val_t SAT = pot_val_t'(CHARGE_CYCLES - 1);

  logic     done;
  pot_val_t latch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      latch <= '0;
      value <= '0;
    end else if (res) begin
      done  <= 1'b0;
      latch <= '0;
      value <= '0;
    end else if (tick) begin
      if (period_start) begin
        done  <= 1'b0;
        latch <= '0;
      end else if (charge_active && charged && !done) begin
        latch <= k;
        done  <= 1'b1;
      end
      // A detect on the last tick itself latches k = CHARGE_CYCLES-1, i.e. SAT.
      if (period_end)
        value <= done ? latch : SAT;
    end
  end

endmodule

// File: rtl/sid_pot_ctrl.sv
// POTX/POTY period sequencer: phi2 tick, phase counter, discharge drive, update strobe.
module sid_pot_ctrl
  import sid_pot_ctrl_pkg::*;
#(
  parameter int DISCHARGE_CYCLES = 256,
  parameter int CHARGE_CYCLES    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phi2,
  input  logic       res,
  input  logic [1:0] charged,
  output logic [1:0] discharge,
  output logic [7:0] pot_x,
  output logic [7:0] pot_y,
  output logic       update
);

  if (!pot_param_ok(DISCHARGE_CYCLES)) begin : g_bad_discharge
    $error("sid_pot_ctrl: DISCHARGE_CYCLES must be 1..256");
  end
  if (!pot_param_ok(CHARGE_CYCLES)) begin : g_bad_charge
    $error("sid_pot_ctrl: CHARGE_CYCLES must be 1..256");
  end

  localparam pot_phase_t PH_DIS    = pot_phase_t'(DISCHARGE_CYCLES);
  localparam pot_phase_t PH_DIS_M1 = pot_phase_t'(DISCHARGE_CYCLES - 1);
  localparam pot_phase_t PH_LAST   = pot_phase_t'(DISCHARGE_CYCLES + CHARGE_CYCLES - 1);

  logic       phi2_d;
  logic       tick;
  pot_phase_t phase;
  pot_val_t   k;
  logic       charge_active;
  logic       period_start;
  logic       period_end;
  pot_o_t     pot_o;
  pot_i_t     pot_i;
  logic [POT_CH-1:0][7:0] value;

  assign tick          = phi2_d & ~phi2;
  assign charge_active = (phase >= PH_DIS);
  assign period_start  = (phase == '0);
  assign period_end    = (phase == PH_LAST);
  assign k             = pot_val_t'(phase - PH_DIS);

  assign pot_i.charged = charged;
  assign discharge     = pot_o.discharge;
  assign pot_x         = value[0];
  assign pot_y         = value[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phi2_d <= 1'b0;
    else     phi2_d <= phi2;
  end

  // Nothing moves without a phi2 falling edge, so a stalled phi2 freezes the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase           <= '0;
      pot_o.discharge <= '1;
      update          <= 1'b0;
    end else if (res) begin
      phase           <= '0;
      pot_o.discharge <= '1;
      update          <= 1'b0;
    end else begin
      update <= tick && period_end;
      if (tick) begin
        phase <= period_end ? '0 : phase + 1'b1;
        if (phase == PH_DIS_M1)
          pot_o.discharge <= '0;
        else if (period_end)
          pot_o.discharge <= '1;
      end
    end
  end

  for (genvar i = 0; i < POT_CH; i++) begin : g_ch
    sid_pot_channel #(
      .CHARGE_CYCLES(CHARGE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .res          (res),
      .tick         (tick),
      .charge_active(charge_active),
      .period_start (period_start),
      .period_end   (period_end),
      .k            (k),
      .charged      (pot_i.charged[i]),
      .value        (value[i])
    );
  end

endmodule

// File: tb/tb_sid_pot_ctrl.sv
// Directed bench for sid_pot_ctrl: 256/256 main instance plus a 4/8 short-period instance.
module tb_sid_pot_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       phi2 = 1'b0;
  logic       res = 1'b0;
  logic       res_s = 1'b0;
  logic [1:0] charged = 2'b00;
  logic [1:0] charged_s = 2'b00;
  logic [1:0] discharge, discharge_s;
  logic [7:0] pot_x, pot_y, pot_x_s, pot_y_s;
  logic       update, update_s;

  int checks = 0;
  int errors = 0;
  int upd_seen;

  always #5 clk = ~clk;

  sid_pot_ctrl #(.DISCHARGE_CYCLES(256), .CHARGE_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .phi2(phi2), .res(res), .charged(charged),
    .discharge(discharge), .pot_x(pot_x), .pot_y(pot_y), .update(update)
  );

  sid_pot_ctrl #(.DISCHARGE_CYCLES(4), .CHARGE_CYCLES(8)) dut_s (
    .clk(clk), .rst(rst), .phi2(phi2), .res(res_s), .charged(charged_s),
    .discharge(discharge_s), .pot_x(pot_x_s), .pot_y(pot_y_s), .update(update_s)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One phi2 falling edge; returns #1 after the clk edge that consumed it.
  task automatic tick();
    @(negedge clk) phi2 = 1'b1;
    @(negedge clk) phi2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Full 512-tick period; rise offsets are k values, 999 = never.
  task automatic period(input int xr, input int yr, input bit pulse_x);
    for (int p = 0; p < 512; p++) begin
      charged[0] = pulse_x ? (p == 256 + xr) : (p >= 256 + xr);
      charged[1] = (p >= 256 + yr);
      tick();
      chk("discharge", 9'(discharge), (((p + 1) % 512) < 256) ? 9'h3 : 9'h0);
      chk("update", 9'(update), 9'(p == 511));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_discharge", 9'(discharge), 9'h3);
    chk("rst_pot_x", 9'(pot_x), 9'h0);
    chk("rst_pot_y", 9'(pot_y), 9'h0);
    chk("rst_update", 9'(update), 9'h0);
    @(negedge clk) rst = 1'b0;

    period(100, 999, 1'b0);
    chk("p1_pot_x", 9'(pot_x), 9'd100);
    chk("p1_pot_y", 9'(pot_y), 9'd255);

    period(0, 0, 1'b0);
    chk("all_pot_x", 9'(pot_x), 9'd0);
    chk("all_pot_y", 9'(pot_y), 9'd0);

    period(50, 255, 1'b1);
    chk("pulse_pot_x", 9'(pot_x), 9'd50);
    chk("late_pot_y", 9'(pot_y), 9'd255);

    // Bus reset mid-charge of the second period
    period(100, 999, 1'b0);
    chk("pre_res_pot_x", 9'(pot_x), 9'd100);
    for (int p = 0; p < 300; p++) begin
      charged[0] = (p >= 276);
      charged[1] = 1'b0;
      tick();
      chk("part_update", 9'(update), 9'h0);
    end
    @(negedge clk) res = 1'b1;
    @(posedge clk);
    #1;
    chk("res_pot_x", 9'(pot_x), 9'h0);
    chk("res_pot_y", 9'(pot_y), 9'h0);
    chk("res_discharge", 9'(discharge), 9'h3);
    chk("res_update", 9'(update), 9'h0);
    tick();
    tick();
    chk("res_hold_pot_x", 9'(pot_x), 9'h0);
    chk("res_hold_discharge", 9'(discharge), 9'h3);
    @(negedge clk) res = 1'b0;
    charged = 2'b00;
    period(7, 999, 1'b0);
    chk("post_res_pot_x", 9'(pot_x), 9'd7);
    chk("post_res_pot_y", 9'(pot_y), 9'd255);

    // phi2 stall at k=81; charged toggled during the stall must be ignored
    for (int p = 0; p < 337; p++) begin
      charged[0] = (p >= 356);
      charged[1] = 1'b0;
      tick();
    end
    @(negedge clk) phi2 = 1'b1;
    upd_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      charged = (c == 1000) ? 2'b11 : 2'b00;
      @(posedge clk);
      #1;
      if (update) upd_seen++;
    end
    charged = 2'b00;
    chk("stall_update", 9'(upd_seen), 9'h0);
    chk("stall_discharge", 9'(discharge), 9'h0);
    chk("stall_pot_x", 9'(pot_x), 9'd7);
    chk("stall_pot_y", 9'(pot_y), 9'd255);
    for (int p = 337; p < 512; p++) begin
      charged[0] = (p >= 356);
      tick();
      chk("resume_discharge", 9'(discharge), (((p + 1) % 512) < 256) ? 9'h3 : 9'h0);
      chk("resume_update", 9'(update), 9'(p == 511));
    end
    chk("resume_pot_x", 9'(pot_x), 9'd100);
    chk("resume_pot_y", 9'(pot_y), 9'd255);

    // Async reset mid-operation takes effect without a clock edge
    @(negedge clk) rst = 1'b1;
    #1;
    chk("arst_pot_x", 9'(pot_x), 9'h0);
    chk("arst_pot_y", 9'(pot_y), 9'h0);
    chk("arst_update", 9'(update), 9'h0);
    chk("arst_discharge_s", 9'(discharge_s), 9'h3);
    @(negedge clk) rst = 1'b0;

    // Short-period instance: 12 ticks per period, no charge -> saturate at 7
    for (int n = 0; n < 36; n++) begin
      tick();
      chk("s_discharge", 9'(discharge_s), (((n + 1) % 12) < 4) ? 9'h3 : 9'h0);
      chk("s_update", 9'(update_s), 9'((n % 12) == 11));
      if ((n % 12) == 11) begin
        chk("s_pot_x", 9'(pot_x_s), 9'd7);
        chk("s_pot_y", 9'(pot_y_s), 9'd7);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
